// File: rtl/m_axi_lite_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package m_axi_lite_master_pkg;

    // AXI response codes as returned on BRESP/RRESP
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExOkay = 2'b01;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdData,
        StRsp
    } state_e;

endpackage

// File: rtl/m_axi_lite_master.sv
// AXI4-Lite master: one local command in, one AXI-Lite transaction out, one response back.
// At most one transaction in flight; every output comes straight from a register.
module m_axi_lite_master
    import m_axi_lite_master_pkg::*;
#(
    parameter int unsigned P_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned P_M_AXI_ADDR_WIDTH = 4,
    parameter logic [2:0]  P_M_AXI_PROT       = 3'b000
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    // local command port
    input  logic                              i_cmd_valid,
    output logic                              o_cmd_ready,
    input  logic                              i_cmd_wr,
    input  logic [P_M_AXI_ADDR_WIDTH-1:0]     i_cmd_addr,
    input  logic [P_M_AXI_DATA_WIDTH-1:0]     i_cmd_wdata,
    input  logic [P_M_AXI_DATA_WIDTH/8-1:0]   i_cmd_wstrb,
    // local response port
    output logic                              o_rsp_valid,
    input  logic                              i_rsp_ready,
    output logic                              o_rsp_wr,
    output logic [P_M_AXI_DATA_WIDTH-1:0]     o_rsp_rdata,
    output logic [1:0]                        o_rsp_resp,
    output logic                              o_busy,
    // write address channel
    output logic [P_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    // write data channel
    output logic [P_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [P_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    // write response channel
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    // read address channel
    output logic [P_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    // read data channel
    input  logic [P_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int unsigned StrbW = P_M_AXI_DATA_WIDTH / 8;

    state_e                          state_q;
    logic                            cmd_ready_q;
    logic                            busy_q;
    logic                            awvalid_q;
    logic                            wvalid_q;
    logic                            arvalid_q;
    logic                            bready_q;
    logic                            rready_q;
    // AW and W complete independently; both must be seen before waiting for B
    logic                            aw_done_q;
    logic                            w_done_q;
    logic [P_M_AXI_ADDR_WIDTH-1:0]   awaddr_q;
    logic [P_M_AXI_ADDR_WIDTH-1:0]   araddr_q;
    logic [P_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [StrbW-1:0]                wstrb_q;
    logic                            rsp_valid_q;
    logic                            rsp_wr_q;
    logic [P_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [1:0]                      rsp_resp_q;

    // Transaction FSM with all outputs registered alongside the state
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RespOkay;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (i_cmd_wr) begin
                            awaddr_q  <= i_cmd_addr;
                            wdata_q   <= i_cmd_wdata;
                            wstrb_q   <= i_cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= StWrReq;
                        end else begin
                            araddr_q  <= i_cmd_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= StRdReq;
                        end
                    end
                end
                StWrReq: begin
                    if (awvalid_q && M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && M_AXI_WREADY) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_done_q && w_done_q) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= StWrResp;
                    end
                end
                StWrResp: begin
                    if (M_AXI_BVALID) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_wr_q    <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= M_AXI_BRESP;
                        state_q     <= StRsp;
                    end
                end
                StRdReq: begin
                    if (arvalid_q && M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdData;
                    end
                end
                StRdData: begin
                    if (M_AXI_RVALID) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_wr_q    <= 1'b0;
                        rsp_rdata_q <= M_AXI_RDATA;
                        rsp_resp_q  <= M_AXI_RRESP;
                        state_q     <= StRsp;
                    end
                end
                StRsp: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_cmd_ready   = cmd_ready_q;
    assign o_busy        = busy_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_wr      = rsp_wr_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_resp    = rsp_resp_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = P_M_AXI_PROT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = P_M_AXI_PROT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_m_axi_lite_master.sv
// Bench for m_axi_lite_master: a delay-programmable 4-register slave, a hold-until-ready
// protocol checker, and a word-level reference model of the register file and responses.
module tb_m_axi_lite_master;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    always #5 clk = ~clk;

    logic        i_cmd_valid, o_cmd_ready, i_cmd_wr;
    logic [3:0]  i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic [3:0]  i_cmd_wstrb;
    logic        o_rsp_valid, i_rsp_ready, o_rsp_wr, o_busy;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    m_axi_lite_master dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_wr(o_rsp_wr),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp), .o_busy(o_busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
        .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0;
    logic [31:0] s_mem [4];
    logic        s_got_aw, s_got_w, s_bpend, s_rpend;
    logic [3:0]  s_awaddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    int          s_bcnt, s_rcnt;
    logic        aw_hs, w_hs, ar_hs, w_fire;
    logic [3:0]  s_a;
    logic [31:0] s_d;
    logic [3:0]  s_s;

    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = wvalid && (w_wait >= w_delay);
    assign arready = arvalid && (ar_wait >= ar_delay);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign s_a     = s_got_aw ? s_awaddr : awaddr;
    assign s_d     = s_got_w ? s_wdata : wdata;
    assign s_s     = s_got_w ? s_wstrb : wstrb;
    assign w_fire  = (s_got_aw || aw_hs) && (s_got_w || w_hs);

    // ready stall counters
    always @(posedge clk) begin
        aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
        w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
        ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
    end

    // slave register file and B/R channel generation
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_got_aw <= 1'b0; s_got_w <= 1'b0; s_bpend <= 1'b0; s_rpend <= 1'b0;
            s_bcnt <= 0; s_rcnt <= 0; bvalid <= 1'b0; rvalid <= 1'b0;
            bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
            for (int i = 0; i < 4; i++) s_mem[i] <= '0;
        end else begin
            if (aw_hs) begin s_awaddr <= awaddr; s_got_aw <= 1'b1; end
            if (w_hs) begin s_wdata <= wdata; s_wstrb <= wstrb; s_got_w <= 1'b1; end
            if (w_fire) begin
                if (s_a < 4'd4) begin
                    for (int b = 0; b < 4; b++)
                        if (s_s[b]) s_mem[s_a[1:0]][8*b +: 8] <= s_d[8*b +: 8];
                    bresp <= 2'b00;
                end else begin
                    bresp <= 2'b11;
                end
                s_got_aw <= 1'b0;
                s_got_w  <= 1'b0;
                if (b_delay == 0) bvalid <= 1'b1;
                else begin s_bpend <= 1'b1; s_bcnt <= b_delay - 1; end
            end
            if (s_bpend) begin
                if (s_bcnt == 0) begin bvalid <= 1'b1; s_bpend <= 1'b0; end
                else s_bcnt <= s_bcnt - 1;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (ar_hs) begin
                case (araddr)
                    4'd0, 4'd2, 4'd3: begin rdata <= s_mem[araddr[1:0]]; rresp <= 2'b00; end
                    4'd1:             begin rdata <= s_mem[1]; rresp <= 2'b10; end
                    default:          begin rdata <= 32'hBAD0_0000 | 32'(araddr); rresp <= 2'b11; end
                endcase
                if (r_delay == 0) rvalid <= 1'b1;
                else begin s_rpend <= 1'b1; s_rcnt <= r_delay - 1; end
            end
            if (s_rpend) begin
                if (s_rcnt == 0) begin rvalid <= 1'b1; s_rpend <= 1'b0; end
                else s_rcnt <= s_rcnt - 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // handshake tallies
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    always @(posedge clk) begin
        if (aw_hs) n_aw <= n_aw + 1;
        if (w_hs) n_w <= n_w + 1;
        if (bvalid && bready) n_b <= n_b + 1;
        if (ar_hs) n_ar <= n_ar + 1;
        if (rvalid && rready) n_r <= n_r + 1;
    end

    // VALID must stay up with stable payload until its READY
    logic        p_aw, p_w, p_ar;
    logic [3:0]  p_awaddr, p_araddr, p_wstrb;
    logic [31:0] p_wdata;
    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
            p_awaddr <= '0; p_araddr <= '0; p_wstrb <= '0; p_wdata <= '0;
        end else begin
            if (p_aw) check("aw_held", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_w) check("w_held", {wvalid, wstrb, wdata}, {1'b1, p_wstrb, p_wdata});
            if (p_ar) check("ar_held", {arvalid, araddr}, {1'b1, p_araddr});
            p_aw <= awvalid && !awready; p_awaddr <= awaddr;
            p_w  <= wvalid && !wready;   p_wdata <= wdata; p_wstrb <= wstrb;
            p_ar <= arvalid && !arready; p_araddr <= araddr;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [4];

    function automatic logic [1:0] ref_resp(input logic wr, input logic [3:0] addr);
        if (addr >= 4'd4) return 2'b11;
        if (!wr && addr == 4'd1) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] strb);
        logic [31:0] mask = 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
        return (old & ~mask) | (nw & mask);
    endfunction

    task automatic set_delays(input int a, input int w, input int ar, input int b, input int r);
        aw_delay = a; w_delay = w; ar_delay = ar; b_delay = b; r_delay = r;
    endtask

    // One command end to end; exp_lat <= 0 skips the latency check
    task automatic do_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int hold, input int exp_lat);
        int n, lat, aw0, w0, b0, ar0, r0;
        logic [31:0] exp_rd;
        logic [1:0]  exp_rs;
        n = 0;
        while (!o_cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("cmd_ready_idle", o_cmd_ready, 1'b1);
        aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
        exp_rs = ref_resp(wr, addr);
        if (wr) begin
            exp_rd = 32'h0;
            if (addr < 4'd4) ref_mem[addr[1:0]] = ref_merge(ref_mem[addr[1:0]], wd, ws);
        end else begin
            exp_rd = (addr < 4'd4) ? ref_mem[addr[1:0]] : (32'hBAD0_0000 | 32'(addr));
        end
        i_cmd_valid = 1'b1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_wdata = wd; i_cmd_wstrb = ws;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        check("accepted", {o_busy, o_cmd_ready}, 2'b10);
        lat = 1;
        while (!o_rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check("rsp_valid", o_rsp_valid, 1'b1);
        if (exp_lat > 0) check("latency", 64'(lat), 64'(exp_lat));
        check("rsp_fields", {o_rsp_wr, o_rsp_rdata, o_rsp_resp}, {wr, exp_rd, exp_rs});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("rsp_hold", {o_rsp_valid, o_cmd_ready, o_busy, o_rsp_wr, o_rsp_rdata, o_rsp_resp},
                  {1'b1, 1'b0, 1'b1, wr, exp_rd, exp_rs});
        end
        i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        i_rsp_ready = 1'b0;
        check("rsp_done", {o_rsp_valid, o_cmd_ready, o_busy}, 3'b010);
        check("hs_counts", {4'(n_aw - aw0), 4'(n_w - w0), 4'(n_b - b0), 4'(n_ar - ar0), 4'(n_r - r0)},
              wr ? {4'd1, 4'd1, 4'd1, 4'd0, 4'd0} : {4'd0, 4'd0, 4'd0, 4'd1, 4'd1});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int n;
        logic seen;
        i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0;
        i_cmd_wstrb = '0; i_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {o_cmd_ready, o_busy, o_rsp_valid, awvalid, wvalid, arvalid, bready, rready},
              8'b1000_0000);
        check("reset_data", {awaddr, araddr, wdata, wstrb, o_rsp_wr, o_rsp_rdata, o_rsp_resp},
              79'h0);
        check("prot", {awprot, arprot}, 6'b000_000);
        #3 rstn = 1'b1;
        @(posedge clk); #1;

        // zero-wait slave: write then read back, minimum latencies
        set_delays(0, 0, 0, 0, 0);
        do_cmd(1'b1, 4'd2, 32'h0000_0041, 4'hF, 0, 4);
        check("slave_tx_byte", s_mem[2], 32'h0000_0041);
        do_cmd(1'b1, 4'd3, 32'h0000_005A, 4'hF, 0, 4);
        do_cmd(1'b0, 4'd3, 32'hFFFF_FFFF, 4'h0, 0, 3);

        // W completes several cycles before AW
        set_delays(5, 2, 0, 0, 0);
        do_cmd(1'b1, 4'd0, 32'hCAFE_F00D, 4'hF, 0, 0);

        // response back-pressure, then a back-to-back command; read of reg 1 returns SLVERR
        set_delays(0, 0, 0, 0, 0);
        do_cmd(1'b1, 4'd1, 32'h1234_5678, 4'h5, 10, 4);
        do_cmd(1'b0, 4'd1, 32'h0, 4'h0, 0, 3);
        do_cmd(1'b0, 4'd7, 32'h0, 4'h0, 0, 3);

        // reset while waiting for B
        set_delays(0, 0, 0, 8, 0);
        i_cmd_valid = 1'b1; i_cmd_wr = 1'b1; i_cmd_addr = 4'd2;
        i_cmd_wdata = 32'h0000_00EE; i_cmd_wstrb = 4'hF;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        n = 0;
        while (!bready && n < 30) begin @(posedge clk); #1; n++; end
        check("reached_wr_resp", bready, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("async_reset", {awvalid, wvalid, arvalid, bready, rready, o_rsp_valid, o_busy, o_cmd_ready},
              8'b0000_0001);
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
        @(posedge clk); @(posedge clk);
        #3 rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (o_rsp_valid || o_busy) seen = 1'b1;
        end
        check("no_rsp_after_reset", seen, 1'b0);
        set_delays(0, 0, 0, 0, 0);
        do_cmd(1'b1, 4'd2, 32'h0000_0077, 4'hF, 0, 4);
        do_cmd(1'b0, 4'd2, 32'h0, 4'h0, 0, 3);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            do_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), $urandom,
                   4'($urandom_range(0, 15)), $urandom_range(0, 3), 0);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
